// File: rtl/bsg_nasti_client_req_rr.sv
// NASTI client request serializer: round-robin AR/AW arbitration, W burst
// packing and a non-blocking B-response queue of completed write burst ids.
module bsg_nasti_client_req_rr #(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned id_width_p   = 5,
    parameter int unsigned data_width_p = 64,
    parameter int unsigned req_width_p  = 2 + (((addr_width_p + id_width_p) > (data_width_p + 1))
                                               ? (addr_width_p + id_width_p) : (data_width_p + 1)),
    parameter int unsigned b_els_p      = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    nasti_ar_valid_i,
    input  logic [addr_width_p-1:0] nasti_ar_addr_i,
    input  logic [id_width_p-1:0]   nasti_ar_id_i,
    output logic                    nasti_ar_ready_o,

    input  logic                    nasti_aw_valid_i,
    input  logic [addr_width_p-1:0] nasti_aw_addr_i,
    input  logic [id_width_p-1:0]   nasti_aw_id_i,
    output logic                    nasti_aw_ready_o,

    input  logic                    nasti_w_valid_i,
    input  logic [data_width_p-1:0] nasti_w_data_i,
    input  logic                    nasti_w_last_i,
    output logic                    nasti_w_ready_o,

    output logic                    nasti_b_valid_o,
    output logic [id_width_p-1:0]   nasti_b_id_o,
    output logic [1:0]              nasti_b_resp_o,
    input  logic                    nasti_b_ready_i,

    output logic                    req_valid_o,
    output logic [req_width_p-1:0]  req_data_o,
    input  logic                    req_yumi_i
);

    localparam int unsigned addr_pay_w_lp = addr_width_p + id_width_p;
    localparam int unsigned data_pay_w_lp = data_width_p + 1;
    localparam int unsigned min_req_w_lp  = 2 + ((addr_pay_w_lp > data_pay_w_lp) ? addr_pay_w_lp : data_pay_w_lp);
    localparam int unsigned pay_w_lp      = req_width_p - 2;
    localparam int unsigned cnt_w_lp      = $clog2(b_els_p + 1);
    localparam int unsigned ptr_w_lp      = (b_els_p > 1) ? $clog2(b_els_p) : 1;

    // Elaboration-time parameter legality
    if (req_width_p < min_req_w_lp) begin : g_bad_req_width
        $error("req_width_p too small for address or data payload");
    end
    if (b_els_p < 1) begin : g_bad_b_els
        $error("b_els_p must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        WADDR = 3'd2,
        WWAIT = 3'd3,
        WDATA = 3'd4,
        WLAST = 3'd5
    } state_e;

    localparam logic RR_READ  = 1'b0;
    localparam logic RR_WRITE = 1'b1;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic                     r_rr_last;
    logic                     r_req_valid;
    logic                     r_w_ready;
    logic                     r_b_valid;
    logic [req_width_p-1:0]   r_req_data;
    logic [id_width_p-1:0]    r_burst_id;

    logic [id_width_p-1:0]    r_b_mem [b_els_p];
    logic [ptr_w_lp-1:0]      r_b_wr_ptr;
    logic [ptr_w_lp-1:0]      r_b_rd_ptr;
    logic [cnt_w_lp-1:0]      r_b_cnt;
    logic [cnt_w_lp-1:0]      w_b_cnt_nxt;

    logic                     w_rd_elig;
    logic                     w_wr_elig;
    logic                     w_grant_rd;
    logic                     w_grant_wr;
    logic                     w_cap_en;
    logic [req_width_p-1:0]   w_cap_pkt;
    logic                     w_push;
    logic                     w_pop;
    logic [req_width_p-1:0]   w_ar_pkt;
    logic [req_width_p-1:0]   w_aw_pkt;
    logic [req_width_p-1:0]   w_w_pkt;

    assign w_ar_pkt = {2'b00, pay_w_lp'({nasti_ar_id_i, nasti_ar_addr_i})};
    assign w_aw_pkt = {2'b01, pay_w_lp'({nasti_aw_id_i, nasti_aw_addr_i})};
    assign w_w_pkt  = {1'b1, nasti_w_last_i, pay_w_lp'({nasti_w_last_i, nasti_w_data_i})};

    // A write may only start if its eventual B entry is guaranteed a slot
    assign w_rd_elig = nasti_ar_valid_i;
    assign w_wr_elig = nasti_aw_valid_i && (r_b_cnt < cnt_w_lp'(b_els_p));
    assign w_pop     = r_b_valid && nasti_b_ready_i;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(b_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Next-state, grant and capture selection
    always_comb begin
        w_state_nxt = r_state;
        w_grant_rd  = 1'b0;
        w_grant_wr  = 1'b0;
        w_cap_en    = 1'b0;
        w_cap_pkt   = w_ar_pkt;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_elig && (!w_rd_elig || (r_rr_last == RR_READ))) begin
                    w_grant_wr  = 1'b1;
                    w_cap_en    = 1'b1;
                    w_cap_pkt   = w_aw_pkt;
                    w_state_nxt = WADDR;
                end else if (w_rd_elig) begin
                    w_grant_rd  = 1'b1;
                    w_cap_en    = 1'b1;
                    w_cap_pkt   = w_ar_pkt;
                    w_state_nxt = RADDR;
                end
            end
            RADDR: if (req_yumi_i) w_state_nxt = IDLE;
            WADDR: if (req_yumi_i) w_state_nxt = WWAIT;
            WWAIT: begin
                if (nasti_w_valid_i) begin
                    w_cap_en    = 1'b1;
                    w_cap_pkt   = w_w_pkt;
                    w_state_nxt = nasti_w_last_i ? WLAST : WDATA;
                end
            end
            WDATA: if (req_yumi_i) w_state_nxt = WWAIT;
            WLAST: begin
                if (req_yumi_i) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // B occupancy next value
    always_comb begin
        w_b_cnt_nxt = r_b_cnt;
        case ({w_push, w_pop})
            2'b10:   w_b_cnt_nxt = r_b_cnt + cnt_w_lp'(1);
            2'b01:   w_b_cnt_nxt = r_b_cnt - cnt_w_lp'(1);
            default: w_b_cnt_nxt = r_b_cnt;
        endcase
    end

    // Control state and registered status outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= IDLE;
            r_rr_last   <= RR_READ;
            r_req_valid <= 1'b0;
            r_w_ready   <= 1'b0;
            r_b_valid   <= 1'b0;
            r_b_cnt     <= '0;
            r_b_wr_ptr  <= '0;
            r_b_rd_ptr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_valid <= (w_state_nxt == RADDR) || (w_state_nxt == WADDR) ||
                           (w_state_nxt == WDATA) || (w_state_nxt == WLAST);
            r_w_ready   <= (w_state_nxt == WWAIT);
            r_b_valid   <= (w_b_cnt_nxt != '0);
            r_b_cnt     <= w_b_cnt_nxt;
            if (w_grant_wr)
                r_rr_last <= RR_WRITE;
            else if (w_grant_rd)
                r_rr_last <= RR_READ;
            if (w_push)
                r_b_wr_ptr <= ptr_inc(r_b_wr_ptr);
            if (w_pop)
                r_b_rd_ptr <= ptr_inc(r_b_rd_ptr);
        end
    end

    // Datapath registers; control state qualifies their contents
    always_ff @(posedge clk_i) begin
        if (w_cap_en)
            r_req_data <= w_cap_pkt;
        if (w_grant_wr)
            r_burst_id <= nasti_aw_id_i;
        if (w_push)
            r_b_mem[r_b_wr_ptr] <= r_burst_id;
    end

    assign nasti_ar_ready_o = w_grant_rd;
    assign nasti_aw_ready_o = w_grant_wr;
    assign nasti_w_ready_o  = r_w_ready;
    assign nasti_b_valid_o  = r_b_valid;
    assign nasti_b_id_o     = r_b_mem[r_b_rd_ptr];
    assign nasti_b_resp_o   = 2'b00;
    assign req_valid_o      = r_req_valid;
    assign req_data_o       = r_req_data;

endmodule

// File: tb/tb_bsg_nasti_client_req_rr.sv
// Scoreboard bench for bsg_nasti_client_req_rr: random AXI-style master,
// transaction-level model of grants, request stream and B ordering.
module tb_bsg_nasti_client_req_rr;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 5;
    localparam int unsigned DW = 64;
    localparam int unsigned RW = 2 + DW + 1;
    localparam int unsigned BE = 3;

    logic          clk_i;
    logic          reset_n_i;
    logic          ar_valid, aw_valid, w_valid, w_last, b_ready, req_yumi_i;
    logic [AW-1:0] ar_addr, aw_addr;
    logic [IW-1:0] ar_id, aw_id;
    logic [DW-1:0] w_data;
    logic          ar_ready_o, aw_ready_o, w_ready_o, b_valid_o, req_valid_o;
    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic [RW-1:0] req_data_o;

    bsg_nasti_client_req_rr #(
        .addr_width_p(AW), .id_width_p(IW), .data_width_p(DW),
        .req_width_p(RW), .b_els_p(BE)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .nasti_ar_valid_i(ar_valid), .nasti_ar_addr_i(ar_addr),
        .nasti_ar_id_i(ar_id), .nasti_ar_ready_o(ar_ready_o),
        .nasti_aw_valid_i(aw_valid), .nasti_aw_addr_i(aw_addr),
        .nasti_aw_id_i(aw_id), .nasti_aw_ready_o(aw_ready_o),
        .nasti_w_valid_i(w_valid), .nasti_w_data_i(w_data),
        .nasti_w_last_i(w_last), .nasti_w_ready_o(w_ready_o),
        .nasti_b_valid_o(b_valid_o), .nasti_b_id_o(b_id_o),
        .nasti_b_resp_o(b_resp_o), .nasti_b_ready_i(b_ready),
        .req_valid_o(req_valid_o), .req_data_o(req_data_o),
        .req_yumi_i(req_yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk_addr(input logic [1:0] t, input logic [IW-1:0] id, input logic [AW-1:0] a);
        logic [RW-1:0] p;
        p = '0;
        p[RW-1 -: 2] = t;
        p[AW +: IW]  = id;
        p[AW-1:0]    = a;
        return p;
    endfunction

    function automatic logic [RW-1:0] mk_data(input logic last, input logic [DW-1:0] d);
        logic [RW-1:0] p;
        p[RW-1 -: 2] = {1'b1, last};
        p[DW]        = last;
        p[DW-1:0]    = d;
        return p;
    endfunction

    // Reference model state (owned by the monitor)
    logic [RW-1:0] exp_req[$];
    logic [IW-1:0] exp_b[$];
    bit            burst_open, rr_last_wr, first_seen;
    logic [IW-1:0] cur_bid;
    logic [RW-1:0] first_pop;
    int unsigned   n_rd;
    bit            ar_hs, aw_hs, w_hs;

    // Monitor: compare every cycle at the falling edge, then advance the model
    always @(negedge clk_i) begin
        bit            idle, e_aw, e_ar;
        logic [RW-1:0] p;
        if (!reset_n_i) begin
            exp_req.delete();
            exp_b.delete();
            burst_open = 0; rr_last_wr = 0; first_seen = 0;
            ar_hs = 0; aw_hs = 0; w_hs = 0;
        end else begin
            idle = (exp_req.size() == 0) && !burst_open;
            e_aw = idle && aw_valid && (exp_b.size() < BE) && (!ar_valid || !rr_last_wr);
            e_ar = idle && ar_valid && !e_aw;
            chk("aw_ready", RW'(aw_ready_o), RW'(e_aw));
            chk("ar_ready", RW'(ar_ready_o), RW'(e_ar));
            chk("w_ready", RW'(w_ready_o), RW'(burst_open && exp_req.size() == 0));
            chk("req_valid", RW'(req_valid_o), RW'(exp_req.size() != 0));
            chk("b_valid", RW'(b_valid_o), RW'(exp_b.size() != 0));
            if (b_valid_o && exp_b.size() != 0) begin
                chk("b_id", RW'(b_id_o), RW'(exp_b[0]));
                chk("b_resp", RW'(b_resp_o), '0);
            end
            ar_hs = ar_valid && ar_ready_o;
            aw_hs = aw_valid && aw_ready_o;
            w_hs  = w_valid && w_ready_o;
            if (req_valid_o && req_yumi_i && exp_req.size() != 0) begin
                p = exp_req.pop_front();
                chk("req_data", req_data_o, p);
                if (!first_seen) begin first_pop = req_data_o; first_seen = 1; end
                if (p[RW-1 -: 2] == 2'b11) begin
                    exp_b.push_back(cur_bid);
                    burst_open = 0;
                end
            end
            if (b_valid_o && b_ready && exp_b.size() != 0) void'(exp_b.pop_front());
            if (ar_hs) begin
                exp_req.push_back(mk_addr(2'b00, ar_id, ar_addr));
                rr_last_wr = 0;
                n_rd++;
            end
            if (aw_hs) begin
                exp_req.push_back(mk_addr(2'b01, aw_id, aw_addr));
                rr_last_wr = 1;
                burst_open = 1;
                cur_bid = aw_id;
            end
            if (w_hs) exp_req.push_back(mk_data(w_last, w_data));
        end
    end

    // Driver state
    int unsigned p_ar, p_aw, p_w, p_yumi, p_b, max_beats, aw_beats_cur;
    int          w_bursts[$];
    bit          hold_data;

    function automatic bit roll(input int unsigned pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
        if (ar_hs) ar_valid = 0;
        if (!ar_valid && roll(p_ar)) begin
            ar_valid = 1; ar_addr = $urandom; ar_id = IW'($urandom);
        end
        if (aw_hs) begin aw_valid = 0; w_bursts.push_back(int'(aw_beats_cur)); end
        if (!aw_valid && roll(p_aw)) begin
            aw_valid = 1; aw_addr = $urandom; aw_id = IW'($urandom);
            aw_beats_cur = $urandom_range(max_beats, 1);
        end
        if (w_hs) begin
            w_valid = 0;
            if (w_bursts.size() != 0) begin
                w_bursts[0] = w_bursts[0] - 1;
                if (w_bursts[0] == 0) void'(w_bursts.pop_front());
            end
        end
        if (!w_valid && w_bursts.size() != 0 && roll(p_w)) begin
            w_valid = 1; w_data = {$urandom, $urandom}; w_last = (w_bursts[0] == 1);
        end
        req_yumi_i = req_valid_o && !(hold_data && req_data_o[RW-1 -: 2] == 2'b10) && roll(p_yumi);
        b_ready = roll(p_b);
    endtask

    task automatic set_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input int unsigned beats);
        aw_valid = 1; aw_id = id; aw_addr = a; aw_beats_cur = beats;
    endtask

    initial begin
        int unsigned   rd_before;
        bit            found;
        logic [RW-1:0] cap;
        reset_n_i = 0;
        ar_valid = 0; aw_valid = 0; w_valid = 0; w_last = 0; b_ready = 0; req_yumi_i = 0;
        ar_addr = '0; aw_addr = '0; ar_id = '0; aw_id = '0; w_data = '0;
        p_ar = 0; p_aw = 0; p_w = 100; p_yumi = 100; p_b = 100; max_beats = 4;
        aw_beats_cur = 1; hold_data = 0;

        // Contended start: both classes valid out of reset, write must win
        ar_valid = 1; ar_addr = 32'h100; ar_id = 5'd1;
        set_aw(5'd2, 32'h200, 1);
        #1;
        chk("reset_req_valid", RW'(req_valid_o), '0);
        chk("reset_b_valid", RW'(b_valid_o), '0);
        chk("reset_w_ready", RW'(w_ready_o), '0);
        repeat (2) @(posedge clk_i);
        #2 reset_n_i = 1;
        repeat (20) step();
        chk("first_seen", RW'(first_seen), RW'(1'b1));
        chk("first_type", RW'(first_pop[RW-1 -: 2]), RW'(2'b01));
        chk("first_addr", RW'(first_pop[AW-1:0]), RW'(32'h200));

        // Four-beat burst with id 3
        set_aw(5'd3, 32'h300, 4);
        repeat (20) step();

        // B queue filled and held: writes stall, reads still proceed
        p_b = 0; p_aw = 100; max_beats = 3;
        repeat (60) step();
        chk("b_held_valid", RW'(b_valid_o), RW'(1'b1));
        rd_before = n_rd;
        ar_valid = 1; ar_addr = 32'hABC0; ar_id = 5'd7;
        repeat (10) step();
        chk("read_with_b_blocked", RW'(n_rd > rd_before), RW'(1'b1));
        p_aw = 0; p_b = 100;
        repeat (40) step();

        // Hold yumi low in WDATA with a queued B pending
        p_b = 0;
        set_aw(5'd9, 32'h900, 1);
        repeat (10) step();
        hold_data = 1;
        set_aw(5'd10, 32'hA00, 2);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (req_valid_o && req_data_o[RW-1 -: 2] == 2'b10) found = 1;
        end
        chk("reach_wdata", RW'(found), RW'(1'b1));
        if (found) begin
            cap = req_data_o;
            for (int i = 0; i < 10; i++) begin
                step();
                chk("hold_valid", RW'(req_valid_o), RW'(1'b1));
                chk("hold_data", req_data_o, cap);
                chk("hold_w_ready", RW'(w_ready_o), '0);
            end
            chk("b_pending_before_reset", RW'(b_valid_o), RW'(1'b1));
        end

        // Asynchronous reset mid-burst, checked before the next edge
        #2 reset_n_i = 0;
        #1;
        chk("async_req_valid", RW'(req_valid_o), '0);
        chk("async_b_valid", RW'(b_valid_o), '0);
        chk("async_w_ready", RW'(w_ready_o), '0);
        ar_valid = 0; aw_valid = 0; w_valid = 0; req_yumi_i = 0; b_ready = 0;
        w_bursts.delete();
        hold_data = 0;
        repeat (3) @(posedge clk_i);
        #2 reset_n_i = 1;

        // Randomized traffic
        p_ar = 40; p_aw = 40; p_w = 70; p_yumi = 70; p_b = 50; max_beats = 6;
        repeat (3000) step();

        // Drain
        p_ar = 0; p_aw = 0; p_w = 100; p_yumi = 100; p_b = 100;
        repeat (200) step();
        chk("drain_req_valid", RW'(req_valid_o), '0);
        chk("drain_b_valid", RW'(b_valid_o), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_nasti_client_req_rr.md
BSG_NASTI_CLIENT_REQ_RR -- requirements
Module: bsg_nasti_client_req_rr

Interface
REQ-001 Parameter addr_width_p, default 32, NASTI address width.
REQ-002 Parameter id_width_p, default 5, NASTI transaction id width.
REQ-003 Parameter data_width_p, default 64, NASTI write data width.
REQ-004 Parameter req_width_p, default 2+max(addr_width_p+id_width_p, data_width_p+1); smaller values SHALL be rejected at elaboration.
REQ-005 Parameter b_els_p, default 4, B-response queue depth; must be at least 1.
REQ-006 Port clk_i, input, 1, sole clock; all state SHALL be rising-edge clocked on it.
REQ-007 Port reset_n_i, input, 1; reset SHALL be asynchronous and active-low.
REQ-008 Ports nasti_ar_valid_i in 1, nasti_ar_addr_i in addr_width_p, nasti_ar_id_i in id_width_p, nasti_ar_ready_o out 1: read address channel.
REQ-009 Ports nasti_aw_valid_i in 1, nasti_aw_addr_i in addr_width_p, nasti_aw_id_i in id_width_p, nasti_aw_ready_o out 1: write address channel.
REQ-010 Ports nasti_w_valid_i in 1, nasti_w_data_i in data_width_p, nasti_w_last_i in 1, nasti_w_ready_o out 1: write data channel.
REQ-011 Ports nasti_b_valid_o out 1, nasti_b_id_o out id_width_p, nasti_b_resp_o out 2, nasti_b_ready_i in 1: write response channel.
REQ-012 Ports req_valid_o out 1, req_data_o out req_width_p, req_yumi_i in 1: serialized request stream; yumi SHALL only be asserted while valid.

Function
REQ-013 req_data_o SHALL be {type[1:0], payload}, type in MSBs; payload LSB-aligned and zero-padded.
REQ-014 Type 00 SHALL be read address, payload {id, addr}; type 01 write address, {id, addr}; type 10 write data, {0, data}; type 11 last write data, {1, data}.
REQ-015 FSM states SHALL be IDLE, RADDR, WADDR, WWAIT, WDATA, WLAST.
REQ-016 In IDLE, write SHALL be eligible iff aw_valid and B-queue occupancy < b_els_p; read SHALL be eligible iff ar_valid.
REQ-017 When both are eligible, grant SHALL go to the class not granted last (rr_last_r); with one eligible, that class SHALL be granted; rr_last_r SHALL update on every grant.
REQ-018 nasti_ar_ready_o and nasti_aw_ready_o SHALL be asserted only in IDLE, for the granted class only, never both in one cycle.
REQ-019 Read grant: capture type 00 packet into the output register, go to RADDR; write grant: capture type 01 packet, capture aw_id into the burst id register, go to WADDR.
REQ-020 req_valid_o SHALL equal (state in {RADDR, WADDR, WDATA, WLAST}) and be driven from registers only, with no combinational input-to-output path.
REQ-021 RADDR with yumi -> IDLE; WADDR with yumi -> WWAIT.
REQ-022 nasti_w_ready_o SHALL be asserted only in WWAIT.
REQ-023 In WWAIT, a w beat SHALL be captured as type 10 -> WDATA, or as type 11 when w_last -> WLAST.
REQ-024 WDATA with yumi -> WWAIT.
REQ-025 WLAST with yumi -> IDLE and SHALL push the burst id into the B queue in the same cycle.
REQ-026 Unlike single-outstanding designs, the FSM SHALL NOT wait for B acceptance; new requests proceed while B entries drain.
REQ-027 The B queue SHALL be FIFO-ordered; nasti_b_valid_o = queue not empty; nasti_b_id_o = head id; nasti_b_resp_o = 2'b00.
REQ-028 The head SHALL pop on b_valid & b_ready.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged; push when full cannot occur by REQ-016.
REQ-030 Occupancy counter SHALL be clog2(b_els_p+1) bits and pointers SHALL wrap modulo b_els_p, including non-power-of-two depths.
REQ-031 Beat count SHALL be unbounded; a burst ends only on w_last.
REQ-032 Input changes while not ready SHALL have no effect.

Reset
REQ-033 On reset_n_i low, immediately and asynchronously: state SHALL be IDLE, rr_last_r = read (so the first contended grant goes to write), B queue empty, req_valid_o = 0, nasti_b_valid_o = 0, w_ready = 0.
REQ-034 req_data_o and the burst id register need no reset; reset mid-burst SHALL discard the burst and all queued B entries.
REQ-035 Deassertion SHALL be synchronized externally; the block SHALL leave IDLE no earlier than the first clock edge after deassertion.

Verification
REQ-036 Scenario: ar and aw both valid from reset, addr 0x100 and 0x200 -> first req type 01 addr 0x200, then type 00 addr 0x100.
REQ-037 Scenario: aw id 3 followed by 4 beats (last on beat 4), yumi every cycle -> req sequence 01, 10, 10, 10, 11; b_valid with id 3 the cycle after last yumi.
REQ-038 Scenario: b_els_p = 2, b_ready = 0, three write bursts -> third aw_ready stays 0 while occupancy is 2; it rises one cycle after the first b handshake.
REQ-039 Scenario: b_ready = 0 with a queued B, then ar valid -> read request issued, proving non-blocking B.
REQ-040 Scenario: yumi held low 10 cycles in WDATA -> req_valid_o and req_data_o stable, w_ready_o = 0 throughout.
REQ-041 Scenario: reset asserted asynchronously mid WDATA -> req_valid_o = 0 and b_valid = 0 before the next clock edge.
